// File: rtl/acc_proc_core.sv
// Accumulator processor core: program memory, data memory and a one-instruction-per-cycle
// execute stage under an IDLE/RUN/HALT controller with optional single-stepping.
`timescale 1ns/1ps

module acc_proc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_mode,
  input  logic              step,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+3:0] prog_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              zero_out,
  output logic              busy,
  output logic              halted
);

  localparam int IW    = ADDR_W + 4;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_LD   = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_ST   = 4'h7,
    OP_LDI  = 4'h8,
    OP_ADDI = 4'h9,
    OP_SHR  = 4'hA,
    OP_NAND = 4'hB,
    OP_NOPC = 4'hC,
    OP_NOPD = 4'hD,
    OP_HALT = 4'hE,
    OP_BNEZ = 4'hF
  } opcode_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [IW-1:0]     imem [DEPTH];
  logic [DATA_W-1:0] dmem [DEPTH];

  logic [IW-1:0]     instr;
  opcode_t           opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] acc_next;
  logic [ADDR_W-1:0] pc_next;
  logic              store_en;
  logic              taken;
  logic              halt_cond;
  logic              exec;

  assign instr   = imem[pc];
  assign opcode  = opcode_t'(instr[3:0]);
  assign operand = instr[IW-1:4];
  assign src     = dmem[operand];
  assign imm     = DATA_W'($signed(operand));

  // run=0 has priority, so a dropping run never lets a final instruction slip through.
  assign exec = (state == ST_RUN) && run && (!step_mode || step);

  always_comb begin
    acc_next = acc;
    store_en = 1'b0;
    taken    = 1'b0;
    unique case (opcode)
      OP_LD:   acc_next = src;
      OP_ADD:  acc_next = acc + src;
      OP_SUB:  acc_next = acc - src;
      OP_AND:  acc_next = acc & src;
      OP_OR:   acc_next = acc | src;
      OP_XOR:  acc_next = acc ^ src;
      OP_SHL:  acc_next = acc << 1;
      OP_ST:   store_en = 1'b1;
      OP_LDI:  acc_next = imm;
      OP_ADDI: acc_next = acc + imm;
      OP_SHR:  acc_next = acc >> 1;
      OP_NAND: acc_next = ~(acc & src);
      OP_BNEZ: taken    = (acc != '0);
      OP_NOPC, OP_NOPD, OP_HALT: ;
      default: ;
    endcase
    pc_next   = taken ? operand : pc + 1'b1;
    // The last address halts unless a taken branch leaves it (self-loop included).
    halt_cond = (opcode == OP_HALT) || ((pc == PC_LAST) && !taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= '0;
      acc   <= '0;
      // NOTE: both memories are explicitly cleared on reset, so they are built from
      // resettable flops rather than a RAM macro; a blocking loop variable is fine here
      // because only the array elements are state and those use <=.
      for (int i = 0; i < DEPTH; i++) begin
        imem[i] <= '0;
        dmem[i] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          pc <= '0;
          if (prog_we) imem[prog_addr] <= prog_data;
          if (run) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!run) begin
            state <= ST_IDLE;
            pc    <= '0;
          end else if (exec) begin
            acc <= acc_next;
            if (store_en) dmem[operand] <= acc;
            if (halt_cond) state <= ST_HALT;
            else           pc    <= pc_next;
          end
        end
        ST_HALT: begin
          if (!run) begin
            state <= ST_IDLE;
            pc    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_rdata = dmem[dbg_addr];
  assign pc_out    = pc;
  assign acc_out   = acc;
  assign zero_out  = (acc == '0);
  assign busy      = (state == ST_RUN);
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_acc_proc_core.sv
// Self-checking bench for acc_proc_core: table of small programs with expected final
// state routed through a scoreboard queue, plus sequences for stepping, RUN-time writes and reset.
`timescale 1ns/1ps

module tb_acc_proc_core;

  localparam logic [3:0] LD = 4'h0, ADD = 4'h1, SUB = 4'h2, AND_ = 4'h3, OR_ = 4'h4,
                         XOR_ = 4'h5, SHL = 4'h6, ST = 4'h7, LDI = 4'h8, ADDI = 4'h9,
                         SHR = 4'hA, NAND_ = 4'hB, NOP = 4'hC, NOPD = 4'hD, HALT = 4'hE,
                         BNEZ = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0, step_mode = 1'b0, step = 1'b0, prog_we = 1'b0;
  logic [3:0] prog_addr = '0, dbg_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] dbg_rdata, acc_out;
  logic [3:0] pc_out;
  logic       zero_out, busy, halted;

  logic        run2 = 1'b0, prog_we2 = 1'b0;
  logic [4:0]  prog_addr2 = '0, dbg_addr2 = '0, pc_out2;
  logic [8:0]  prog_data2 = '0;
  logic [15:0] dbg_rdata2, acc_out2;
  logic        zero_out2, busy2, halted2;

  always #5 clk = ~clk;

  acc_proc_core dut (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .pc_out(pc_out), .acc_out(acc_out),
    .zero_out(zero_out), .busy(busy), .halted(halted)
  );

  acc_proc_core #(.DATA_W(16), .ADDR_W(5)) dut_wide (
    .clk(clk), .rst(rst), .run(run2), .step_mode(1'b0), .step(1'b0),
    .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2),
    .dbg_addr(dbg_addr2), .dbg_rdata(dbg_rdata2), .pc_out(pc_out2), .acc_out(acc_out2),
    .zero_out(zero_out2), .busy(busy2), .halted(halted2)
  );

  typedef struct {
    string           name;
    logic [15:0][7:0] prog;
    logic [7:0]      acc;
    logic [3:0]      pc;
    int              cycles;
    logic [3:0]      dbg_addr;
    logic [7:0]      dbg;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] acc;
    logic [3:0] pc;
    int         cycles;
    logic [3:0] dbg_addr;
    logic [7:0] dbg;
  } exp_t;

  localparam int NV = 10;
  vec_t tv [NV];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prg(input int v, input int a, input logic [3:0] opc, input logic [3:0] opr);
    tv[v].prog[a] = {opr, opc};
  endtask

  task automatic set_exp(input int v, input string name, input logic [7:0] acc,
                         input logic [3:0] pc, input int cyc, input logic [3:0] da,
                         input logic [7:0] d);
    tv[v].name = name; tv[v].acc = acc; tv[v].pc = pc; tv[v].cycles = cyc;
    tv[v].dbg_addr = da; tv[v].dbg = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] w);
    prog_we = 1'b1; prog_addr = a; prog_data = w;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic load_vec(input int v);
    for (int a = 0; a < 16; a++) load_word(4'(a), tv[v].prog[a]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 32'(pc_out), 32'h0);
    check({tag, "_acc"}, 32'(acc_out), 32'h0);
    check({tag, "_zero"}, 32'(zero_out), 32'h1);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
    check({tag, "_dbg"}, 32'(dbg_rdata), 32'h0);
  endtask

  initial begin
    exp_t e;
    int   cyc;

    for (int v = 0; v < NV; v++) tv[v].prog = {16{{NOP, NOP}}};
    for (int v = 0; v < NV; v++) tv[v].prog = {16{8'h0C}};
    // LDI 5, ST 2, LDI 0, ADD 2, ADD 2
    prg(0, 0, LDI, 4'd5); prg(0, 1, ST, 4'd2); prg(0, 2, LDI, 4'd0);
    prg(0, 3, ADD, 4'd2); prg(0, 4, ADD, 4'd2); prg(0, 5, HALT, 4'd0);
    set_exp(0, "ld_st_add", 8'h0A, 4'd5, 6, 4'd2, 8'h05);
    // 1 - 3 wraps
    prg(1, 0, LDI, 4'd3); prg(1, 1, ST, 4'd1); prg(1, 2, LDI, 4'd1);
    prg(1, 3, SUB, 4'd1); prg(1, 4, HALT, 4'd0);
    set_exp(1, "sub_wrap", 8'hFE, 4'd4, 5, 4'd1, 8'h03);
    prg(2, 0, LDI, 4'd6); prg(2, 1, ST, 4'd0); prg(2, 2, LDI, 4'd3);
    prg(2, 3, XOR_, 4'd0); prg(2, 4, OR_, 4'd0); prg(2, 5, AND_, 4'd0); prg(2, 6, HALT, 4'd0);
    set_exp(2, "logic_ops", 8'h06, 4'd6, 7, 4'd0, 8'h06);
    prg(3, 0, LDI, 4'hF); prg(3, 1, SHR, 4'd0); prg(3, 2, ST, 4'd3);
    prg(3, 3, LDI, 4'd5); prg(3, 4, NAND_, 4'd3); prg(3, 5, HALT, 4'd0);
    set_exp(3, "shr_nand", 8'hFA, 4'd5, 6, 4'd3, 8'h7F);
    prg(4, 0, LDI, 4'h8); prg(4, 1, SHL, 4'd0); prg(4, 2, SHL, 4'd0);
    prg(4, 3, ADDI, 4'd7); prg(4, 4, NOPD, 4'd0); prg(4, 5, HALT, 4'd0);
    set_exp(4, "shl_addi", 8'hE7, 4'd5, 6, 4'd9, 8'h00);
    prg(5, 0, LDI, 4'd3); prg(5, 1, ADDI, 4'hF); prg(5, 2, BNEZ, 4'd1); prg(5, 3, HALT, 4'd0);
    set_exp(5, "countdown", 8'h00, 4'd3, 8, 4'd0, 8'h00);
    set_exp(6, "all_nop", 8'h00, 4'd15, 16, 4'd0, 8'h00);
    prg(7, 0, LDI, 4'd4); prg(7, 1, ST, 4'd5); prg(7, 2, HALT, 4'd0);
    set_exp(7, "st_keeps_acc", 8'h04, 4'd2, 3, 4'd5, 8'h04);
    // Jump to the top of IMEM; the instruction at the last address commits then halts.
    prg(8, 0, LDI, 4'd2); prg(8, 1, BNEZ, 4'd14); prg(8, 14, ST, 4'd6); prg(8, 15, ADDI, 4'd1);
    set_exp(8, "last_pc_commit", 8'h03, 4'd15, 4, 4'd6, 8'h02);
    prg(9, 0, LDI, 4'd7); prg(9, 1, ST, 4'd8); prg(9, 2, ADD, 4'd8); prg(9, 3, ADD, 4'd8);
    prg(9, 4, SUB, 4'd8); prg(9, 5, ST, 4'd9); prg(9, 6, LD, 4'd8); prg(9, 7, HALT, 4'd0);
    set_exp(9, "ld_dmem", 8'h07, 4'd7, 8, 4'd9, 8'h0E);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");
    check("reset_wide_acc", 32'(acc_out2), 32'h0);
    check("reset_wide_pc", 32'(pc_out2), 32'h0);

    // Table-driven programs through the scoreboard
    for (int v = 0; v < NV; v++) begin
      do_reset();
      load_vec(v);
      exp_q.push_back('{tv[v].name, tv[v].acc, tv[v].pc, tv[v].cycles, tv[v].dbg_addr, tv[v].dbg});
      run = 1'b1;
      @(posedge clk); #1;
      check({tv[v].name, "_busy"}, 32'(busy), 32'h1);
      cyc = 0;
      while (!halted && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      e = exp_q.pop_front();
      dbg_addr = e.dbg_addr;
      #1;
      check({e.name, "_cycles"}, 32'(cyc), 32'(e.cycles));
      check({e.name, "_acc"}, 32'(acc_out), 32'(e.acc));
      check({e.name, "_pc"}, 32'(pc_out), 32'(e.pc));
      check({e.name, "_zero"}, 32'(zero_out), 32'(e.acc == 8'h00));
      check({e.name, "_dbg"}, 32'(dbg_rdata), 32'(e.dbg));
      repeat (2) @(posedge clk);
      #1;
      check({e.name, "_hold_pc"}, 32'(pc_out), 32'(e.pc));
      run = 1'b0;
      @(posedge clk); #1;
      check({e.name, "_idle_busy"}, 32'(busy | halted), 32'h0);
      check({e.name, "_idle_pc"}, 32'(pc_out), 32'h0);
      check({e.name, "_retain_acc"}, 32'(acc_out), 32'(e.acc));
    end

    // Single-step: LDI 7, SHL, HALT
    do_reset();
    load_word(4'd0, {4'd7, LDI});
    load_word(4'd1, {4'd0, SHL});
    load_word(4'd2, {4'd0, HALT});
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("step_idle_pc", 32'(pc_out), 32'h0);
    check("step_idle_busy", 32'(busy), 32'h0);
    step_mode = 1'b1;
    run = 1'b1;
    @(posedge clk); #1;
    check("step_enter_busy", 32'(busy), 32'h1);
    repeat (5) @(posedge clk);
    #1;
    check("step_wait_acc", 32'(acc_out), 32'h0);
    check("step_wait_pc", 32'(pc_out), 32'h0);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("step1_acc", 32'(acc_out), 32'h07);
    check("step1_pc", 32'(pc_out), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("step_hold_acc", 32'(acc_out), 32'h07);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("step2_acc", 32'(acc_out), 32'h0E);
    check("step2_pc", 32'(pc_out), 32'h2);
    step_mode = 1'b0;
    @(posedge clk); #1;
    check("step_free_halt", 32'(halted), 32'h1);
    check("step_free_pc", 32'(pc_out), 32'h2);
    run = 1'b0;
    @(posedge clk); #1;

    // Self-loop, IMEM write ignored during RUN, then reset mid-RUN
    do_reset();
    load_word(4'd0, {4'd1, LDI});
    load_word(4'd1, {4'd4, ST});
    load_word(4'd2, {4'd2, BNEZ});
    run = 1'b1;
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    check("loop_busy", 32'(busy), 32'h1);
    check("loop_not_halted", 32'(halted), 32'h0);
    check("loop_pc", 32'(pc_out), 32'h2);
    load_word(4'd0, {4'd3, LDI});
    run = 1'b0;
    @(posedge clk); #1;
    check("loop_exit_pc", 32'(pc_out), 32'h0);
    run = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rerun_acc", 32'(acc_out), 32'h01);
    @(posedge clk); #1;
    dbg_addr = 4'd4;
    #1;
    check("rerun_dbg", 32'(dbg_rdata), 32'h01);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrun_rst");
    run = 1'b0;
    @(posedge clk); #1;

    // Wide instance: LDI -1, SHR, then NOPs to the last address
    do_reset();
    for (int a = 0; a < 32; a++) begin
      prog_we2 = 1'b1;
      prog_addr2 = 5'(a);
      prog_data2 = (a == 0) ? {5'h1F, LDI} : (a == 1) ? {5'h00, SHR} : {5'h00, NOP};
      @(posedge clk); #1;
    end
    prog_we2 = 1'b0;
    run2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wide_ldi", 32'(acc_out2), 32'hFFFF);
    cyc = 1;
    while (!halted2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("wide_cycles", 32'(cyc), 32'd32);
    check("wide_acc", 32'(acc_out2), 32'h7FFF);
    check("wide_pc", 32'(pc_out2), 32'd31);
    run2 = 1'b0;
    @(posedge clk); #1;
    check("wide_idle_pc", 32'(pc_out2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_proc_core.md
ACC_PROC_CORE -- requirements
Module: acc_proc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: accumulator/data-memory word width (>=4).
REQ-002 SHALL have parameter ADDR_W, default 4: PC/operand width; IMEM and DMEM depth = 2**ADDR_W; instruction width IW = 4+ADDR_W.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 run  in  1  level; high requests execution, low returns core to IDLE.
REQ-006 step_mode  in  1  1 = single-step; 0 = free-run.
REQ-007 step  in  1  one-cycle pulse; advances one instruction in step mode.
REQ-008 prog_we  in  1  IMEM write strobe.
REQ-009 prog_addr  in  ADDR_W  IMEM write address.
REQ-010 prog_data  in  IW  instruction; [3:0] opcode, [IW-1:4] operand.
REQ-011 dbg_addr  in  ADDR_W  DMEM debug read address.
REQ-012 dbg_rdata  out  DATA_W  combinational DMEM[dbg_addr].
REQ-013 pc_out  out  ADDR_W  current PC.
REQ-014 acc_out  out  DATA_W  accumulator.
REQ-015 zero_out  out  1  acc_out == 0.
REQ-016 busy  out  1  state == RUN.
REQ-017 halted  out  1  state == HALT.

Function
REQ-018 FSM states IDLE, RUN, HALT; IDLE->RUN when run=1; RUN->HALT on halt condition; RUN/HALT->IDLE when run=0 (priority over halt).
REQ-019 Entering RUN SHALL set PC=0; acc and DMEM retained.
REQ-020 IMEM write (prog_we) SHALL occur only in IDLE; ignored in RUN/HALT.
REQ-021 An instruction executes in one cycle in RUN when step_mode=0, or step_mode=1 and step=1; otherwise PC, acc, DMEM hold.
REQ-022 Operand op = instr[IW-1:4]; S = DMEM[op]; I = op sign-extended to DATA_W.
REQ-023 Opcodes: 0 LD acc=S; 1 ADD acc+=S; 2 SUB acc-=S; 3 AND; 4 OR; 5 XOR (with S); 6 SHL acc<<=1; 7 ST DMEM[op]=acc; 8 LDI acc=I; 9 ADDI acc+=I; A SHR logical >>1; B NAND acc=~(acc&S); C-D NOP; E HALT; F BNEZ op.
REQ-024 Arithmetic SHALL wrap modulo 2**DATA_W; no carry/overflow state.
REQ-025 ST SHALL not modify acc; only ST writes DMEM.
REQ-026 BNEZ taken (acc!=0 before the instruction) SHALL set PC=op, else PC+1.
REQ-027 Non-branch PC SHALL increment by 1.
REQ-028 Halt condition: executing HALT, or executing any instruction at PC=2**ADDR_W-1 other than a taken BNEZ; PC SHALL stay at the executing address in HALT; that instruction's acc/DMEM effect is committed.
REQ-029 BNEZ to own address with acc!=0 SHALL loop indefinitely (no halt).
REQ-030 step pulses outside RUN, or with step_mode=0, SHALL have no effect; step_mode change takes effect next cycle.
REQ-031 dbg_rdata SHALL reflect a same-cycle ST only after the clock edge.

Reset
REQ-032 rst SHALL force state IDLE, PC=0, acc=0, all IMEM and DMEM words 0, taking priority over every other input including mid-RUN.
REQ-033 After reset: pc_out=0, acc_out=0, zero_out=1, busy=0, halted=0, dbg_rdata=0.

Verification
REQ-034 Defaults; load LDI 3, ADDI -1 (op F), BNEZ 1, HALT; run=1 -> acc 3,2,1,0, halted on PC=3 after 8 cycles from RUN entry.
REQ-035 LDI 5, ST 2, LDI 0, ADD 2, ADD 2 -> acc=0x0A, dbg_addr=2 reads 0x05.
REQ-036 IMEM all NOP, run=1 -> halted after 16 cycles with pc_out=15; run=0 -> IDLE, pc_out=0.
REQ-037 step_mode=1, LDI 7 then SHL: no step for 5 cycles -> acc=0; one step -> acc=7; second step -> acc=0x0E.
REQ-038 prog_we during RUN to addr 0 -> IMEM unchanged (verify by rerun); rst asserted mid-RUN -> all outputs at REQ-033 values next cycle.
REQ-039 DATA_W=16, ADDR_W=5: LDI -1, SHR -> acc=0x7FFF; halt at PC 31 with NOP fill.
